alu_exec_ctrl: RTL and testbench

- Multi-cycle sequencer that sits between instruction decode and the 16-bit ALU.
- Accepts one decoded instruction at a time over a valid/ready handshake and reads operands from the register file.
- Extends immediates, drives the ALU enable, opcode and operands, then captures the result and the C/L/F/Z/N flags.
- Writes the result back to the register file and updates the processor status register (PSR).

---
 rtl/alu_exec_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: IDLE/READ/EXEC/WB sequencer between decode, the register file and a 16-bit ALU.
// Optional build macro ALU_CARRY_CHAIN_EN adds the alu_cin output (PSR carry forwarded to ADDC/SUBC/ADDI).
module alu_exec_ctrl #(
  parameter int WIDTH = 16,
  parameter int RADDR = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [7:0]       instr_op,
  input  logic [RADDR-1:0] instr_rdest,
  input  logic [RADDR-1:0] instr_rsrc,
  input  logic [7:0]       instr_imm,
  output logic [RADDR-1:0] rf_raddr_a,
  output logic [RADDR-1:0] rf_raddr_b,
  input  logic [WIDTH-1:0] rf_rdata_a,
  input  logic [WIDTH-1:0] rf_rdata_b,
  output logic             alu_en,
  output logic [7:0]       alu_op,
  output logic [WIDTH-1:0] alu_src,
  output logic [WIDTH-1:0] alu_dst,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_c,
  input  logic             alu_l,
  input  logic             alu_f,
  input  logic             alu_z,
  input  logic             alu_n,
`ifdef ALU_CARRY_CHAIN_EN
  output logic             alu_cin,
`endif
  output logic             rf_we,
  output logic [RADDR-1:0] rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  output logic [4:0]       psr,
  output logic             done,
  output logic             illegal
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t           state_q, state_d;
  logic [7:0]       op_q, op_d;
  logic [RADDR-1:0] rdest_q, rdest_d;
  logic [RADDR-1:0] rsrc_q, rsrc_d;
  logic [7:0]       imm_q, imm_d;
  logic [7:0]       aluop_q, aluop_d;
  logic [WIDTH-1:0] src_q, src_d;
  logic [WIDTH-1:0] dst_q, dst_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [4:0]       flags_q, flags_d;
  logic [4:0]       psr_q, psr_d;

  logic [3:0]       cls, fn;
  logic             cls_illegal, func_undef, psr_upd, no_write;
  logic [WIDTH-1:0] opnd_src, opnd_dst, imm_sext, imm_zext;

  assign cls      = op_q[7:4];
  assign fn       = op_q[3:0];
  assign imm_sext = {{(WIDTH-8){imm_q[7]}}, imm_q};
  assign imm_zext = {{(WIDTH-8){1'b0}}, imm_q};

  // Operand routing by instruction class; unlisted classes are rejected.
  always_comb begin
    cls_illegal = 1'b0;
    opnd_src    = rf_rdata_a;
    opnd_dst    = imm_zext;
    case (cls)
      4'b0000: begin
        opnd_src = rf_rdata_b;
        opnd_dst = rf_rdata_a;
      end
      4'b1000: opnd_dst = rf_rdata_b;
      4'b0101, 4'b1001, 4'b1011, 4'b1101: opnd_dst = imm_sext;
      4'b0110, 4'b0001, 4'b0010, 4'b0011, 4'b1111: opnd_dst = imm_zext;
      default: cls_illegal = 1'b1;
    endcase
  end

  // Defined shift functions are the register forms LSH (0100) and ASHU (0110).
  always_comb begin
    func_undef = 1'b0;
    psr_upd    = 1'b0;
    case (cls)
      4'b0000: begin
        func_undef = !(fn inside {4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110, 4'b0111,
                                  4'b1001, 4'b1010, 4'b1011, 4'b1101, 4'b1110});
        psr_upd    = fn inside {4'b0101, 4'b0110, 4'b0111, 4'b1001, 4'b1010, 4'b1011, 4'b1110};
      end
      4'b1000: func_undef = !(fn inside {4'b0100, 4'b0110});
      4'b0101, 4'b0110, 4'b1001, 4'b1011: psr_upd = 1'b1;
      default: ;
    endcase
  end

  assign no_write = cls_illegal | func_undef | (cls == 4'b1011) | (op_q == 8'h0B);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      rdest_q <= '0;
      rsrc_q  <= '0;
      imm_q   <= '0;
      aluop_q <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
      psr_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rdest_q <= rdest_d;
      rsrc_q  <= rsrc_d;
      imm_q   <= imm_d;
      aluop_q <= aluop_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      psr_q   <= psr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rdest_d     = rdest_q;
    rsrc_d      = rsrc_q;
    imm_d       = imm_q;
    aluop_d     = aluop_q;
    src_d       = src_q;
    dst_d       = dst_q;
    res_d       = res_q;
    flags_d     = flags_q;
    psr_d       = psr_q;
    instr_ready = 1'b0;
    alu_en      = 1'b0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready = reset;
        if (instr_valid) begin
          op_d    = instr_op;
          rdest_d = instr_rdest;
          rsrc_d  = instr_rsrc;
          imm_d   = instr_imm;
          state_d = READ;
        end
      end
      READ: begin
        if (cls_illegal) begin
          state_d = WB;
        end else begin
          src_d   = opnd_src;
          dst_d   = opnd_dst;
          aluop_d = op_q;
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_en  = 1'b1;
        res_d   = alu_result;
        flags_d = {alu_c, alu_l, alu_f, alu_z, alu_n};
        state_d = WB;
      end
      WB: begin
        done    = 1'b1;
        illegal = cls_illegal;
        if (!no_write) begin
          rf_we    = 1'b1;
          rf_waddr = rdest_q;
          rf_wdata = res_q;
        end
        if (psr_upd) psr_d = flags_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rf_raddr_a = rdest_q;
  assign rf_raddr_b = rsrc_q;
  assign alu_op     = aluop_q;
  assign alu_src    = src_q;
  assign alu_dst    = dst_q;
  assign psr        = psr_q;

`ifdef ALU_CARRY_CHAIN_EN
  // Carry-in comes from the PSR left by the previous arithmetic op.
  assign alu_cin = (state_q == EXEC) && ((op_q == 8'h07) || (op_q == 8'h0A) || (cls == 4'b0101))
                   && psr_q[4];
`endif

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: bench-side register file and ALU, directed
// cases from the test plan, then random instructions against a behavioural model.
module tb_alu_exec_ctrl;

  logic        clk, reset, instr_valid, instr_ready;
  logic [7:0]  instr_op, instr_imm, alu_op;
  logic [3:0]  instr_rdest, instr_rsrc, rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [15:0] rf_rdata_a, rf_rdata_b, alu_src, alu_dst, alu_result, rf_wdata;
  logic        alu_en, alu_c, alu_l, alu_f, alu_z, alu_n, rf_we, done, illegal;
  logic [4:0]  psr;

  logic [15:0] rf [16];
  logic        tbWe;
  logic [3:0]  tbAddr;
  logic [15:0] tbData;
  logic [15:0] mReg [16];
  logic [4:0]  mPsr;
  int          assertCount, failCount;

  int          obsLat, aluEnCnt, weCnt, busyReady;
  logic        obsIll;
  logic [3:0]  obsWaddr;
  logic [15:0] obsWdata, obsSrc, obsDst;
  logic [7:0]  obsOp;

  alu_exec_ctrl #(.WIDTH(16), .RADDR(4)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rdest(instr_rdest), .instr_rsrc(instr_rsrc), .instr_imm(instr_imm),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .alu_en(alu_en), .alu_op(alu_op), .alu_src(alu_src), .alu_dst(alu_dst),
    .alu_result(alu_result),
    .alu_c(alu_c), .alu_l(alu_l), .alu_f(alu_f), .alu_z(alu_z), .alu_n(alu_n),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .psr(psr), .done(done), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side ALU: returns {C,L,F,Z,N,result}.
  function automatic logic [20:0] aluModel(input logic [7:0] op, input logic [15:0] s,
                                           input logic [15:0] d);
    logic [3:0]  fn;
    logic [16:0] t;
    logic [15:0] r;
    logic        c, l, f, z, n, shift;
    c = 1'b0; l = 1'b0; f = 1'b0;
    shift = (op[7:4] == 4'b1000);
    fn = (op[7:4] == 4'b0000) ? op[3:0] : op[7:4];
    r = s ^ ~d;
    if (shift) begin
      if (op[3:0] == 4'b0100) r = s << d[3:0];
      else if (op[3:0] == 4'b0110) r = 16'($signed(s) >>> d[3:0]);
    end else begin
      case (fn)
        4'd1: r = s & d;
        4'd2: r = s | d;
        4'd3: r = s ^ d;
        4'd5, 4'd6, 4'd7: begin
          t = {1'b0, s} + {1'b0, d};
          r = t[15:0]; c = t[16];
          f = (s[15] == d[15]) && (r[15] != s[15]);
        end
        4'd9, 4'd10, 4'd11: begin
          t = {1'b0, d} - {1'b0, s};
          r = t[15:0]; c = t[16];
          f = (d[15] != s[15]) && (r[15] != d[15]);
        end
        4'd13: r = (op[7:4] == 4'b0000) ? s : d;
        4'd14: r = s * d;
        4'd15: r = {d[7:0], 8'h00};
        default: ;
      endcase
    end
    z = (r == 16'h0000);
    n = r[15];
    if (!shift && fn == 4'd11) begin
      z = (s == d);
      l = (d < s);
      n = ($signed(d) < $signed(s));
    end
    return {c, l, f, z, n, r};
  endfunction

  assign {alu_c, alu_l, alu_f, alu_z, alu_n, alu_result} = aluModel(alu_op, alu_src, alu_dst);
  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];

  always @(posedge clk) begin
    if (rf_we) rf[rf_waddr] <= rf_wdata;
    else if (tbWe) rf[tbAddr] <= tbData;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic loadReg(input logic [3:0] addr, input logic [15:0] data);
    @(negedge clk);
    tbWe = 1'b1; tbAddr = addr; tbData = data;
    @(posedge clk);
    #1 tbWe = 1'b0;
    mReg[addr] = data;
  endtask

  // Expected operands, illegality, write and PSR-update decisions from the opcode tables.
  task automatic refModel(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                          input logic [7:0] imm, output logic [15:0] eSrc,
                          output logic [15:0] eDst, output logic eIll, output logic eWe,
                          output logic eUpd);
    logic [3:0] cls, fn;
    logic       defR, defSh;
    cls = op[7:4]; fn = op[3:0];
    eIll = cls inside {4'd4, 4'd12, 4'd10, 4'd7, 4'd14};
    eSrc = mReg[rd];
    eDst = {8'h00, imm};
    if (cls == 4'd0) begin
      eSrc = mReg[rs]; eDst = mReg[rd];
    end else if (cls == 4'd8) begin
      eDst = mReg[rs];
    end else if (cls inside {4'd5, 4'd9, 4'd11, 4'd13}) begin
      eDst = {{8{imm[7]}}, imm};
    end
    defR  = fn inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd13, 4'd14};
    defSh = fn inside {4'd4, 4'd6};
    eWe = !eIll && !(cls == 4'd0 && (!defR || fn == 4'd11)) && !(cls == 4'd8 && !defSh)
          && (cls != 4'd11);
    eUpd = (cls == 4'd0 && (fn inside {4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd14}))
           || (cls inside {4'd5, 4'd6, 4'd9, 4'd11});
  endtask

  // Issues one instruction, observes five cycles, checks against the model and updates it.
  task automatic applyStimulus(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                               input logic [7:0] imm);
    logic [15:0] eSrc, eDst;
    logic        eIll, eWe, eUpd;
    logic [20:0] aluOut;
    logic [4:0]  expPsr;
    int          expLat;
    refModel(op, rd, rs, imm, eSrc, eDst, eIll, eWe, eUpd);
    aluOut = aluModel(op, eSrc, eDst);
    expLat = eIll ? 2 : 3;
    expPsr = eUpd ? aluOut[20:16] : mPsr;
    @(negedge clk);
    checkOutput("ready_idle", 32'(instr_ready), 1);
    instr_valid = 1'b1; instr_op = op; instr_rdest = rd; instr_rsrc = rs; instr_imm = imm;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr_op = 8'($urandom); instr_rdest = 4'($urandom);
    instr_rsrc = 4'($urandom); instr_imm = 8'($urandom);
    obsLat = 0; obsIll = 1'b0; obsWaddr = '0; obsWdata = '0; obsSrc = '0; obsDst = '0;
    obsOp = '0; aluEnCnt = 0; weCnt = 0; busyReady = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (rf_we) weCnt++;
      if (k <= expLat && instr_ready) busyReady++;
      if (alu_en) begin
        aluEnCnt++; obsSrc = alu_src; obsDst = alu_dst; obsOp = alu_op;
      end
      if (done && obsLat == 0) begin
        obsLat = k; obsIll = illegal; obsWaddr = rf_waddr; obsWdata = rf_wdata;
      end
    end
    checkOutput("latency", obsLat, expLat);
    checkOutput("illegal", 32'(obsIll), 32'(eIll));
    checkOutput("we_count", weCnt, eWe ? 1 : 0);
    checkOutput("alu_en_count", aluEnCnt, eIll ? 0 : 1);
    checkOutput("ready_busy", busyReady, 0);
    if (!eIll) begin
      checkOutput("alu_op", 32'(obsOp), 32'(op));
      checkOutput("alu_src", 32'(obsSrc), 32'(eSrc));
      checkOutput("alu_dst", 32'(obsDst), 32'(eDst));
    end
    if (eWe) begin
      checkOutput("waddr", 32'(obsWaddr), 32'(rd));
      checkOutput("wdata", 32'(obsWdata), 32'(aluOut[15:0]));
      mReg[rd] = aluOut[15:0];
    end
    checkOutput("psr", 32'(psr), 32'(expPsr));
    checkOutput("rf_dest", 32'(rf[rd]), 32'(mReg[rd]));
    mPsr = expPsr;
  endtask

  initial begin
    int          accepts, first, second;
    logic [4:0]  psrBefore;
    logic [15:0] eSrc, eDst;
    logic        eIll, eWe, eUpd;
    logic [20:0] aluOut;
    assertCount = 0; failCount = 0;
    reset = 1'b0; instr_valid = 1'b0; instr_op = '0; instr_rdest = '0; instr_rsrc = '0;
    instr_imm = '0; tbWe = 1'b0; tbAddr = '0; tbData = '0; mPsr = '0;
    for (int i = 0; i < 16; i++) begin
      rf[i] = '0; mReg[i] = '0;
    end

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(instr_ready), 0);
    checkOutput("rst_psr", 32'(psr), 0);
    checkOutput("rst_rf_we", 32'(rf_we), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_alu_en", 32'(alu_en), 0);
    checkOutput("rst_alu_op", 32'(alu_op), 0);
    checkOutput("rst_alu_src", 32'(alu_src), 0);
    checkOutput("rst_wdata", 32'(rf_wdata), 0);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) loadReg(4'(i), 16'($urandom));
    loadReg(4'd1, 16'h7FFF);
    loadReg(4'd2, 16'h0001);
    loadReg(4'd3, 16'h0005);
    loadReg(4'd4, 16'hFFFF);
    loadReg(4'd5, 16'h0000);

    // ADD r1,r2: signed overflow into 0x8000
    applyStimulus(8'h05, 4'd1, 4'd2, 8'h00);
    checkOutput("add_waddr", 32'(obsWaddr), 1);
    checkOutput("add_wdata", 32'(obsWdata), 32'h8000);
    checkOutput("add_psr_f", 32'(psr[2]), 1);

    // CMPI equal, then CMPI with sign-extended -1
    applyStimulus(8'hB0, 4'd3, 4'd0, 8'h05);
    checkOutput("cmpi_z", 32'(psr[1]), 1);
    checkOutput("cmpi_l", 32'(psr[3]), 0);
    applyStimulus(8'hB0, 4'd3, 4'd0, 8'hFF);
    checkOutput("cmpi_sext", 32'(obsDst), 32'hFFFF);

    // ANDI zero-extends and leaves PSR alone
    psrBefore = psr;
    applyStimulus(8'h10, 4'd4, 4'd0, 8'h80);
    checkOutput("andi_dst", 32'(obsDst), 32'h0080);
    checkOutput("andi_wdata", 32'(obsWdata), 32'h0080);
    checkOutput("andi_psr_hold", 32'(psr), 32'(psrBefore));

    // LOAD class is rejected with EXEC skipped
    applyStimulus(8'h40, 4'd6, 4'd7, 8'h12);
    checkOutput("ill_latency", obsLat, 2);
    checkOutput("ill_flag", 32'(obsIll), 1);

    // Back-to-back ADDI r5,#1 with instr_valid held
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 8'h50; instr_rdest = 4'd5; instr_rsrc = 4'd0; instr_imm = 8'h01;
    accepts = 0; first = -1; second = -1;
    for (int c = 0; c < 14 && accepts < 2; c++) begin
      if (instr_ready && instr_valid) begin
        accepts++;
        if (accepts == 1) first = c;
        else second = c;
      end
      @(posedge clk);
      #1 if (accepts == 2) instr_valid = 1'b0;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    repeat (5) @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      refModel(8'h50, 4'd5, 4'd0, 8'h01, eSrc, eDst, eIll, eWe, eUpd);
      aluOut = aluModel(8'h50, eSrc, eDst);
      mReg[5] = aluOut[15:0];
      mPsr = aluOut[20:16];
    end
    checkOutput("b2b_accepts", accepts, 2);
    checkOutput("b2b_gap", second - first, 4);
    checkOutput("b2b_r5", 32'(rf[5]), 32'h0002);
    checkOutput("b2b_psr", 32'(psr), 32'(mPsr));

    // Give the PSR a nonzero value, then reset during EXEC of ADD r1,r2
    applyStimulus(8'hB0, 4'd3, 4'd0, 8'h05);
    checkOutput("pre_rst_psr", 32'(psr != 5'd0), 1);
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 8'h05; instr_rdest = 4'd1; instr_rsrc = 4'd2;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    weCnt = 0;
    repeat (2) @(negedge clk);
    checkOutput("mid_exec_en", 32'(alu_en), 1);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_ready", 32'(instr_ready), 0);
    checkOutput("mid_rst_psr", 32'(psr), 0);
    checkOutput("mid_rst_alu_op", 32'(alu_op), 0);
    @(negedge clk);
    if (rf_we || done) weCnt++;
    reset = 1'b1;
    mPsr = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) checkOutput("post_rst_ready", 32'(instr_ready), 1);
      if (rf_we || done) weCnt++;
    end
    checkOutput("post_rst_no_retire", weCnt, 0);
    checkOutput("post_rst_r1", 32'(rf[1]), 32'(mReg[1]));
    checkOutput("post_rst_psr", 32'(psr), 0);

    // Random instructions
    for (int i = 0; i < 40; i++)
      applyStimulus(8'($urandom), 4'($urandom), 4'($urandom), 8'($urandom));
    applyStimulus(8'h09, 4'd8, 4'd8, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
